// File: rtl/irq_controller_if.sv
// Signal bundle between the interrupt controller and the core/CSR side.
// The master side drives device requests and core status; the controller is the slave.
interface irq_controller_if #(
    parameter int NUM_IRQ = 16
);
    logic [NUM_IRQ-1:0] irq_req_i;
    logic [31:0]        mie_i;
    logic               exception_i;
    logic               mret_i;
    logic               stall_i;
    logic               irq_o;
    logic [31:0]        irq_cause_o;
    logic [NUM_IRQ-1:0] irq_ret_o;
    logic               busy_o;

    modport master (
        output irq_req_i, mie_i, exception_i, mret_i, stall_i,
        input  irq_o, irq_cause_o, irq_ret_o, busy_o
    );

    modport slave (
        input  irq_req_i, mie_i, exception_i, mret_i, stall_i,
        output irq_o, irq_cause_o, irq_ret_o, busy_o
    );
endinterface

// File: rtl/irq_controller.sv
// Fixed-priority machine-mode interrupt controller: latches device requests,
// raises one trap at a time towards the CSR block and acknowledges the source on mret.
module irq_controller #(
    parameter int NUM_IRQ    = 16,
    parameter int MIE_OFFSET = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    irq_controller_if.slave   bus
);
    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] TRAP    = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;
    localparam logic [1:0] EXC     = 2'd3;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ret_vec;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [IDX_W-1:0]   winner;
    logic               any_eligible;

    // Requests are latched unmasked; mie only gates which ones may be selected.
    always_comb begin
        eligible = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            eligible[k] = pend_q[k] & bus.mie_i[MIE_OFFSET + k];
        end
    end

    // Scanning downwards lets the lowest eligible index overwrite the rest.
    always_comb begin
        winner       = '0;
        any_eligible = |eligible;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                winner = IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.exception_i) begin
                    state_d = EXC;
                end else if (any_eligible) begin
                    state_d = TRAP;
                    idx_d   = winner;
                end
            end
            TRAP: begin
                if (!bus.stall_i) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.mret_i) begin
                    state_d = IDLE;
                end
            end
            EXC: begin
                if (bus.mret_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ret_vec = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            ret_vec[k] = (state_q == SERVICE) && bus.mret_i && (idx_q == IDX_W'(k));
        end
    end

    // The acknowledge doubles as the pending-clear, so clear beats a same-cycle set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pend_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= (pend_q | bus.irq_req_i) & ~ret_vec;
            idx_q   <= idx_d;
        end
    end

    assign bus.irq_o       = (state_q == TRAP);
    assign bus.irq_cause_o = (state_q == TRAP)
                           ? (32'h8000_0000 | (32'(MIE_OFFSET) + 32'(idx_q)))
                           : 32'h0;
    assign bus.irq_ret_o   = ret_vec;
    assign bus.busy_o      = (state_q != IDLE);
endmodule
